// File: rtl/token_readout_rx.sv
// token_readout_rx: token-driven serial readout of chip hit words into a
// first-word-fall-through FIFO, with saturating hit and lost-word counters.
module token_readout_rx #(
  parameter int unsigned COL_BITS   = 6,
  parameter int unsigned ROW_BITS   = 8,
  parameter int unsigned TS_BITS    = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IDENT      = 0
) (
  input  logic        BUS_CLK,
  input  logic        RST,
  input  logic        CONF_EN,
  input  logic        CONF_GRAY_DIS,
  input  logic [7:0]  CONF_TOKEN_WAIT,
  input  logic [7:0]  CONF_READ_LEN,
  input  logic        RX_TOKEN,
  input  logic        RX_DATA,
  output logic        RX_FREEZE,
  output logic        RX_READ,
  output logic        RX_SCLK,
  input  logic        FIFO_READ,
  output logic        FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic [15:0] HIT_CNT,
  output logic [7:0]  LOST_CNT
);

  localparam int unsigned DATA_BITS  = COL_BITS + ROW_BITS + 2 * TS_BITS;
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  SHIFT_LAST = 8'(2 * DATA_BITS - 1);
  localparam logic [1:0]  IDENT_TAG  = 2'(IDENT);
  localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FREEZE = 3'd1,
    LOAD   = 3'd2,
    SHIFT  = 3'd3,
    STORE  = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [7:0]           phase_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] word_s;
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_r;
  logic [AW:0]          rd_ptr_r;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 write_s;
  logic [15:0]          hit_cnt_r;
  logic [7:0]           lost_cnt_r;
  logic                 freeze_s;
  logic                 read_s;
  logic                 sclk_s;
  logic [31:0]          fifo_data_s;

  function automatic logic [TS_BITS-1:0] gray2bin(input logic [TS_BITS-1:0] g);
    logic [TS_BITS-1:0] b;
    b[TS_BITS-1] = g[TS_BITS-1];
    for (int i = TS_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // State register; the phase counter restarts at zero on every state entry
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_r <= IDLE;
      phase_r <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s != state_r) begin
        phase_r <= 8'd0;
      end else begin
        phase_r <= phase_r + 8'd1;
      end
    end
  end

  // Next-state logic; >= lets a lowered wait/length take effect immediately
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (CONF_EN && RX_TOKEN) state_next_s = FREEZE;
        else                     state_next_s = IDLE;
      end
      FREEZE: begin
        if (phase_r >= CONF_TOKEN_WAIT) state_next_s = LOAD;
        else                            state_next_s = FREEZE;
      end
      LOAD: begin
        if (phase_r >= CONF_READ_LEN) state_next_s = SHIFT;
        else                          state_next_s = LOAD;
      end
      SHIFT: begin
        if (phase_r >= SHIFT_LAST) state_next_s = STORE;
        else                       state_next_s = SHIFT;
      end
      STORE: begin
        if (CONF_EN && RX_TOKEN) state_next_s = FREEZE;
        else                     state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Chip control outputs decoded from the registered state only
  always_comb begin
    freeze_s = 1'b0;
    read_s   = 1'b0;
    sclk_s   = 1'b0;
    case (state_r)
      FREEZE: freeze_s = 1'b1;
      LOAD: begin
        freeze_s = 1'b1;
        read_s   = 1'b1;
      end
      SHIFT: begin
        freeze_s = 1'b1;
        sclk_s   = phase_r[0];
      end
      default: begin
        freeze_s = 1'b0;
        read_s   = 1'b0;
        sclk_s   = 1'b0;
      end
    endcase
  end

  // Deserializer: sample at the end of each cycle where the serial clock is high
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      shift_r <= '0;
    end else if ((state_r == SHIFT) && phase_r[0]) begin
      shift_r <= {shift_r[DATA_BITS-2:0], RX_DATA};
    end
  end

  // Word formatting: optional gray decode of the two timestamp fields
  always_comb begin
    word_s = shift_r;
    if (!CONF_GRAY_DIS) begin
      word_s[DATA_BITS-1 -: TS_BITS]           = gray2bin(shift_r[DATA_BITS-1 -: TS_BITS]);
      word_s[DATA_BITS-TS_BITS-1 -: TS_BITS]   = gray2bin(shift_r[DATA_BITS-TS_BITS-1 -: TS_BITS]);
    end else begin
      word_s = shift_r;
    end
  end

  assign push_s  = (state_r == STORE);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = FIFO_READ && !empty_s;
  // Fullness is judged before the pop, so a push into a full FIFO is lost
  assign write_s = push_s && !full_s;

  // FIFO storage
  always_ff @(posedge BUS_CLK) begin
    if (write_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= word_s;
    end
  end

  // FIFO pointers
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (write_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Saturating hit / lost counters
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      hit_cnt_r  <= 16'd0;
      lost_cnt_r <= 8'd0;
    end else if (push_s) begin
      if (hit_cnt_r != 16'hFFFF) hit_cnt_r <= hit_cnt_r + 16'd1;
      if (full_s && (lost_cnt_r != 8'hFF)) lost_cnt_r <= lost_cnt_r + 8'd1;
    end
  end

  // Output word: stream tag on top, zero pad, data word at the bottom
  always_comb begin
    fifo_data_s                  = 32'd0;
    fifo_data_s[DATA_BITS-1:0]   = mem_r[rd_ptr_r[AW-1:0]];
    fifo_data_s[31:30]           = IDENT_TAG;
  end

  assign RX_FREEZE  = freeze_s;
  assign RX_READ    = read_s;
  assign RX_SCLK    = sclk_s;
  assign FIFO_EMPTY = empty_s;
  assign FIFO_DATA  = fifo_data_s;
  assign HIT_CNT    = hit_cnt_r;
  assign LOST_CNT   = lost_cnt_r;

endmodule

// File: tb/tb_token_readout_rx.sv
// Directed self-checking bench for token_readout_rx with a cycle-level chip model.
module tb_token_readout_rx;

  logic        BUS_CLK;
  logic        RST;
  logic        CONF_EN;
  logic        CONF_GRAY_DIS;
  logic [7:0]  CONF_TOKEN_WAIT;
  logic [7:0]  CONF_READ_LEN;
  logic        RX_TOKEN;
  logic        RX_DATA;
  logic        RX_FREEZE;
  logic        RX_READ;
  logic        RX_SCLK;
  logic        FIFO_READ;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic [15:0] HIT_CNT;
  logic [7:0]  LOST_CNT;

  int errors = 0;
  int checks = 0;

  int n_pre, n_frz, n_load, n_shift, n_sclk, sclk_bad;
  logic first_sclk;
  bit rw_done;

  token_readout_rx #(
    .COL_BITS(6), .ROW_BITS(8), .TS_BITS(8), .FIFO_DEPTH(16), .IDENT(0)
  ) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .CONF_EN(CONF_EN), .CONF_GRAY_DIS(CONF_GRAY_DIS),
    .CONF_TOKEN_WAIT(CONF_TOKEN_WAIT), .CONF_READ_LEN(CONF_READ_LEN),
    .RX_TOKEN(RX_TOKEN), .RX_DATA(RX_DATA), .RX_FREEZE(RX_FREEZE), .RX_READ(RX_READ),
    .RX_SCLK(RX_SCLK), .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA(FIFO_DATA), .HIT_CNT(HIT_CNT), .LOST_CNT(LOST_CNT)
  );

  initial begin
    BUS_CLK = 1'b0;
    forever #5 BUS_CLK = ~BUS_CLK;
  end

  function automatic logic [29:0] ovf_word(input int i);
    return 30'(32'h0123_4567 + i * 32'h0101_0101);
  endfunction

  // Chip model: follows FREEZE/READ/SCLK and serves one word MSB first until STORE.
  task automatic run_word(input logic [29:0] w, input bit keep_token, input bit drop_en);
    bit seen_frz;
    bit seen_load;
    int k;
    n_pre = 0; n_frz = 0; n_load = 0; n_shift = 0; n_sclk = 0; sclk_bad = 0;
    first_sclk = 1'b0; seen_frz = 1'b0; seen_load = 1'b0; k = 0; rw_done = 1'b0;
    for (int c = 0; c < 400 && !rw_done; c++) begin
      @(negedge BUS_CLK);
      if (RX_READ) begin
        n_load++;
        seen_load = 1'b1;
        if (RX_SCLK) sclk_bad++;
        if (drop_en) CONF_EN = 1'b0;
      end else if (RX_FREEZE && seen_load) begin
        if (n_shift == 0) first_sclk = RX_SCLK;
        n_shift++;
        if (k < 30) RX_DATA = w[29-k];
        if (RX_SCLK) begin
          n_sclk++;
          k++;
        end
      end else if (RX_FREEZE) begin
        n_frz++;
        if (RX_SCLK) sclk_bad++;
        if (!seen_frz && !keep_token) RX_TOKEN = 1'b0;
        seen_frz = 1'b1;
      end else if (seen_load) begin
        rw_done = 1'b1;
      end else begin
        n_pre++;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; CONF_EN = 1'b0; CONF_GRAY_DIS = 1'b1; CONF_TOKEN_WAIT = 8'd2;
    CONF_READ_LEN = 8'd1; RX_TOKEN = 1'b0; RX_DATA = 1'b0; FIFO_READ = 1'b0;
    repeat (3) @(negedge BUS_CLK);
    checks++;
    if ({RX_FREEZE, RX_READ, RX_SCLK} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: got %b want 000", {RX_FREEZE, RX_READ, RX_SCLK});
    end
    checks++;
    if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", FIFO_EMPTY); end
    checks++;
    if (HIT_CNT !== 16'd0 || LOST_CNT !== 8'd0) begin
      errors++; $display("FAIL reset_counters: got hit=%0d lost=%0d want 0 0", HIT_CNT, LOST_CNT);
    end
    RST = 1'b0;
    @(negedge BUS_CLK);
  endtask

  task automatic test_basic();
    CONF_EN = 1'b1; CONF_GRAY_DIS = 1'b1; CONF_TOKEN_WAIT = 8'd2; CONF_READ_LEN = 8'd1;
    FIFO_READ = 1'b1;
    repeat (2) @(negedge BUS_CLK);
    FIFO_READ = 1'b0;
    checks++;
    if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL read_when_empty: empty=%b want 1", FIFO_EMPTY); end

    RX_TOKEN = 1'b1;
    run_word(30'h2ABCDEF1, 1'b0, 1'b0);
    checks++;
    if (!rw_done) begin errors++; $display("FAIL basic_timeout: done=%0d want 1", rw_done); end
    checks++;
    if (n_pre != 0 || n_frz != 3 || n_load != 2 || n_shift != 60) begin
      errors++; $display("FAIL basic_phases: pre=%0d frz=%0d load=%0d shift=%0d want 0 3 2 60",
                         n_pre, n_frz, n_load, n_shift);
    end
    checks++;
    if (n_sclk != 30 || first_sclk !== 1'b0 || sclk_bad != 0) begin
      errors++; $display("FAIL basic_sclk: highs=%0d first=%b stray=%0d want 30 0 0", n_sclk, first_sclk, sclk_bad);
    end
    @(negedge BUS_CLK);
    checks++;
    if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== 32'h2ABCDEF1) begin
      errors++; $display("FAIL basic_data: empty=%b data=%h want 0 2abcdef1", FIFO_EMPTY, FIFO_DATA);
    end
    checks++;
    if (HIT_CNT !== 16'd1 || LOST_CNT !== 8'd0 || RX_FREEZE !== 1'b0) begin
      errors++; $display("FAIL basic_counts: hit=%0d lost=%0d freeze=%b want 1 0 0", HIT_CNT, LOST_CNT, RX_FREEZE);
    end
    FIFO_READ = 1'b1;
    @(negedge BUS_CLK);
    FIFO_READ = 1'b0;
    checks++;
    if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL basic_pop: empty=%b want 1", FIFO_EMPTY); end

    CONF_TOKEN_WAIT = 8'd0; CONF_READ_LEN = 8'd0;
    RX_TOKEN = 1'b1;
    run_word(30'h15555555, 1'b0, 1'b0);
    checks++;
    if (!rw_done || n_frz != 1 || n_load != 1 || n_shift != 60) begin
      errors++; $display("FAIL min_wait_phases: done=%0d frz=%0d load=%0d shift=%0d want 1 1 1 60",
                         rw_done, n_frz, n_load, n_shift);
    end
    @(negedge BUS_CLK);
    checks++;
    if (FIFO_DATA !== 32'h15555555 || HIT_CNT !== 16'd2) begin
      errors++; $display("FAIL min_wait_data: data=%h hit=%0d want 15555555 2", FIFO_DATA, HIT_CNT);
    end
    FIFO_READ = 1'b1;
    @(negedge BUS_CLK);
    FIFO_READ = 1'b0;
  endtask

  task automatic test_gray();
    CONF_GRAY_DIS = 1'b0; CONF_TOKEN_WAIT = 8'd1; CONF_READ_LEN = 8'd3;
    RX_TOKEN = 1'b1;
    run_word(30'h20200143, 1'b0, 1'b0);
    checks++;
    if (!rw_done || n_frz != 2 || n_load != 4) begin
      errors++; $display("FAIL gray_phases: done=%0d frz=%0d load=%0d want 1 2 4", rw_done, n_frz, n_load);
    end
    @(negedge BUS_CLK);
    checks++;
    if (FIFO_DATA !== 32'h3FFFC143) begin
      errors++; $display("FAIL gray_80: data=%h want 3fffc143", FIFO_DATA);
    end
    FIFO_READ = 1'b1;
    @(negedge BUS_CLK);
    FIFO_READ = 1'b0;
    RX_TOKEN = 1'b1;
    run_word(30'h00F02A95, 1'b0, 1'b0);
    @(negedge BUS_CLK);
    checks++;
    if (FIFO_DATA !== 32'h00A02A95 || HIT_CNT !== 16'd4) begin
      errors++; $display("FAIL gray_mixed: data=%h hit=%0d want 00a02a95 4", FIFO_DATA, HIT_CNT);
    end
    FIFO_READ = 1'b1;
    @(negedge BUS_CLK);
    FIFO_READ = 1'b0;
    CONF_GRAY_DIS = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp_w [3];
    exp_w[0] = 30'h01234567; exp_w[1] = 30'h3FFFFFFF; exp_w[2] = 30'h00000001;
    CONF_TOKEN_WAIT = 8'd2; CONF_READ_LEN = 8'd1;
    RX_TOKEN = 1'b1;
    run_word(exp_w[0], 1'b1, 1'b0);
    run_word(exp_w[1], 1'b1, 1'b0);
    checks++;
    if (!rw_done || n_pre != 0 || n_frz != 3) begin
      errors++; $display("FAIL b2b_second: done=%0d idle=%0d frz=%0d want 1 0 3", rw_done, n_pre, n_frz);
    end
    run_word(exp_w[2], 1'b0, 1'b0);
    checks++;
    if (!rw_done || n_pre != 0) begin
      errors++; $display("FAIL b2b_third: done=%0d idle=%0d want 1 0", rw_done, n_pre);
    end
    @(negedge BUS_CLK);
    checks++;
    if (RX_FREEZE !== 1'b0 || HIT_CNT !== 16'd7) begin
      errors++; $display("FAIL b2b_end: freeze=%b hit=%0d want 0 7", RX_FREEZE, HIT_CNT);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== {2'b00, exp_w[i]}) begin
        errors++; $display("FAIL b2b_word%0d: empty=%b data=%h want 0 %h", i, FIFO_EMPTY, FIFO_DATA, exp_w[i]);
      end
      FIFO_READ = 1'b1;
      @(negedge BUS_CLK);
      FIFO_READ = 1'b0;
    end
    checks++;
    if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL b2b_drained: empty=%b want 1", FIFO_EMPTY); end
  endtask

  task automatic test_overflow();
    logic [29:0] exp_v;
    for (int i = 0; i < 20; i++) begin
      RX_TOKEN = 1'b1;
      run_word(ovf_word(i), (i != 19), 1'b0);
      checks++;
      if (!rw_done) begin errors++; $display("FAIL ovf_timeout%0d: done=%0d want 1", i, rw_done); end
    end
    @(negedge BUS_CLK);
    checks++;
    if (HIT_CNT !== 16'd27 || LOST_CNT !== 8'd4 || FIFO_DATA !== {2'b00, ovf_word(0)}) begin
      errors++; $display("FAIL ovf_fill: hit=%0d lost=%0d data=%h want 27 4 %h", HIT_CNT, LOST_CNT, FIFO_DATA, ovf_word(0));
    end
    RX_TOKEN = 1'b1;
    run_word(ovf_word(20), 1'b0, 1'b0);
    FIFO_READ = 1'b1;
    @(negedge BUS_CLK);
    FIFO_READ = 1'b0;
    checks++;
    if (HIT_CNT !== 16'd28 || LOST_CNT !== 8'd5 || FIFO_DATA !== {2'b00, ovf_word(1)}) begin
      errors++; $display("FAIL ovf_pop_push: hit=%0d lost=%0d data=%h want 28 5 %h", HIT_CNT, LOST_CNT, FIFO_DATA, ovf_word(1));
    end
    RX_TOKEN = 1'b1;
    run_word(ovf_word(21), 1'b0, 1'b0);
    @(negedge BUS_CLK);
    checks++;
    if (HIT_CNT !== 16'd29 || LOST_CNT !== 8'd5) begin
      errors++; $display("FAIL ovf_refill: hit=%0d lost=%0d want 29 5", HIT_CNT, LOST_CNT);
    end
    RX_TOKEN = 1'b1;
    run_word(ovf_word(22), 1'b0, 1'b0);
    @(negedge BUS_CLK);
    checks++;
    if (HIT_CNT !== 16'd30 || LOST_CNT !== 8'd6) begin
      errors++; $display("FAIL ovf_full_again: hit=%0d lost=%0d want 30 6", HIT_CNT, LOST_CNT);
    end
    for (int i = 0; i < 16; i++) begin
      exp_v = (i < 15) ? ovf_word(i + 1) : ovf_word(21);
      checks++;
      if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== {2'b00, exp_v}) begin
        errors++; $display("FAIL ovf_drain%0d: empty=%b data=%h want 0 %h", i, FIFO_EMPTY, FIFO_DATA, exp_v);
      end
      FIFO_READ = 1'b1;
      @(negedge BUS_CLK);
      FIFO_READ = 1'b0;
    end
    checks++;
    if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL ovf_drained: empty=%b want 1", FIFO_EMPTY); end
  endtask

  task automatic test_rst_mid();
    bit seen_load;
    int shifts;
    RX_TOKEN = 1'b1;
    run_word(30'h00ABC123, 1'b0, 1'b0);
    @(negedge BUS_CLK);
    checks++;
    if (FIFO_EMPTY !== 1'b0 || HIT_CNT !== 16'd31) begin
      errors++; $display("FAIL rst_prefill: empty=%b hit=%0d want 0 31", FIFO_EMPTY, HIT_CNT);
    end
    RX_TOKEN = 1'b1;
    RX_DATA = 1'b1;
    seen_load = 1'b0;
    shifts = 0;
    for (int c = 0; c < 100 && shifts < 10; c++) begin
      @(negedge BUS_CLK);
      if (RX_READ) seen_load = 1'b1;
      else if (RX_FREEZE && seen_load) shifts++;
    end
    checks++;
    if (shifts != 10) begin errors++; $display("FAIL rst_reach_shift: shifts=%0d want 10", shifts); end
    RST = 1'b1;
    @(negedge BUS_CLK);
    checks++;
    if ({RX_FREEZE, RX_READ, RX_SCLK} !== 3'b000 || FIFO_EMPTY !== 1'b1) begin
      errors++; $display("FAIL rst_mid_outputs: ctl=%b empty=%b want 000 1", {RX_FREEZE, RX_READ, RX_SCLK}, FIFO_EMPTY);
    end
    checks++;
    if (HIT_CNT !== 16'd0 || LOST_CNT !== 8'd0) begin
      errors++; $display("FAIL rst_mid_counters: hit=%0d lost=%0d want 0 0", HIT_CNT, LOST_CNT);
    end
    @(negedge BUS_CLK);
    checks++;
    if (RX_FREEZE !== 1'b0) begin errors++; $display("FAIL rst_override: freeze=%b want 0", RX_FREEZE); end
    RST = 1'b0;
    RX_TOKEN = 1'b0;
    RX_DATA = 1'b0;
    repeat (3) @(negedge BUS_CLK);
    checks++;
    if (RX_FREEZE !== 1'b0 || FIFO_EMPTY !== 1'b1 || HIT_CNT !== 16'd0) begin
      errors++; $display("FAIL rst_no_store: freeze=%b empty=%b hit=%0d want 0 1 0", RX_FREEZE, FIFO_EMPTY, HIT_CNT);
    end
  endtask

  task automatic test_conf_drop();
    CONF_EN = 1'b1;
    RX_TOKEN = 1'b1;
    run_word(30'h01F00FF0, 1'b1, 1'b1);
    checks++;
    if (!rw_done || n_shift != 60 || CONF_EN !== 1'b0) begin
      errors++; $display("FAIL drop_complete: done=%0d shift=%0d en=%b want 1 60 0", rw_done, n_shift, CONF_EN);
    end
    @(negedge BUS_CLK);
    checks++;
    if (RX_FREEZE !== 1'b0 || FIFO_EMPTY !== 1'b0 || FIFO_DATA !== 32'h01F00FF0 || HIT_CNT !== 16'd1) begin
      errors++; $display("FAIL drop_stored: freeze=%b empty=%b data=%h hit=%0d want 0 0 01f00ff0 1",
                         RX_FREEZE, FIFO_EMPTY, FIFO_DATA, HIT_CNT);
    end
    repeat (3) @(negedge BUS_CLK);
    checks++;
    if (RX_FREEZE !== 1'b0) begin errors++; $display("FAIL drop_stays_idle: freeze=%b want 0", RX_FREEZE); end
    RX_TOKEN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gray();
    test_back_to_back();
    test_overflow();
    test_rst_mid();
    test_conf_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/token_readout_rx.md
TOKEN_READOUT_RX -- requirements
Module: token_readout_rx

Interface
REQ-001 Parameters (name, default, meaning): COL_BITS, 6, column field width; ROW_BITS, 8, row field width; TS_BITS, 8, width of each timestamp field (LE, TE); FIFO_DEPTH, 16, output FIFO words (power of 2, >=2); IDENT, 0, 2-bit stream tag.
REQ-002 DATA_BITS = COL_BITS+ROW_BITS+2*TS_BITS and SHALL be <=30; the serial word is {LE, TE, ROW, COL}, MSB first.
REQ-003 Ports (name direction width meaning):
 BUS_CLK in 1 sole clock, all logic rising-edge;
 RST in 1 reset, synchronous, active-high;
 CONF_EN in 1 readout enable;
 CONF_GRAY_DIS in 1 1 = store LE/TE raw, 0 = gray-decode;
 CONF_TOKEN_WAIT in 8 FREEZE hold cycles minus 1;
 CONF_READ_LEN in 8 LOAD hold cycles minus 1;
 RX_TOKEN in 1 chip token, synchronous to BUS_CLK;
 RX_DATA in 1 chip serial data;
 RX_FREEZE out 1; RX_READ out 1; RX_SCLK out 1 serial clock to chip;
 FIFO_READ in 1 pop; FIFO_EMPTY out 1; FIFO_DATA out 32 {IDENT[1:0], zero pad, word};
 HIT_CNT out 16 words received; LOST_CNT out 8 words dropped.

Function
REQ-010 FSM states IDLE, FREEZE, LOAD, SHIFT, STORE; one shared 8-bit phase counter cleared on every state entry.
REQ-011 IDLE: CONF_EN=1 and RX_TOKEN=1 -> FREEZE next cycle; else stay.
REQ-012 FREEZE: RX_FREEZE=1; after CONF_TOKEN_WAIT+1 cycles -> LOAD.
REQ-013 LOAD: RX_FREEZE=1, RX_READ=1; after CONF_READ_LEN+1 cycles -> SHIFT.
REQ-014 SHIFT: lasts exactly 2*DATA_BITS cycles; RX_SCLK = phase counter bit 0 (0 on first SHIFT cycle); RX_FREEZE=1; RX_READ=0.
REQ-015 Sampling: at the end of each SHIFT cycle with RX_SCLK=1, RX_DATA shifts into the LSB of a DATA_BITS shift register; DATA_BITS samples total, first sample ends up as MSB.
REQ-016 STORE: one cycle, RX_FREEZE=0; word formed (REQ-017) and pushed (REQ-018); next state FREEZE if CONF_EN=1 and RX_TOKEN=1, else IDLE.
REQ-017 Gray decode (CONF_GRAY_DIS=0): LE and TE each converted independently, b[MSB]=g[MSB], b[i]=b[i+1] xor g[i]; ROW/COL never altered.
REQ-018 Push: FIFO not full -> word written, HIT_CNT+1; full -> word dropped, HIT_CNT+1, LOST_CNT+1; both counters saturate at all-ones.
REQ-019 All FSM outputs decoded from the registered state; no output depends combinationally on an input.
REQ-020 CONF_EN deasserted outside IDLE: current word completes and is stored; then IDLE.
REQ-021 Config inputs are sampled continuously; changing CONF_TOKEN_WAIT/CONF_READ_LEN mid-state takes effect on the next counter compare.
REQ-022 FIFO is first-word-fall-through: FIFO_DATA valid whenever FIFO_EMPTY=0; FIFO_READ with FIFO_EMPTY=0 pops at the clock edge; FIFO_READ when empty is ignored.
REQ-023 Push and pop in the same cycle: not full -> both happen, occupancy unchanged; full -> pop happens, push is dropped and counted lost.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; full = FIFO_DEPTH words held.

Reset
REQ-030 RST=1 at a clock edge: state IDLE, phase counter 0, shift register 0, FIFO emptied (FIFO_EMPTY=1), HIT_CNT=0, LOST_CNT=0, RX_FREEZE=0, RX_READ=0, RX_SCLK=0.
REQ-031 RST mid-readout aborts without storing a word; RST overrides all other inputs.

Verification
REQ-040 Defaults (COL 6, ROW 8, TS 8), WAIT=2, READ_LEN=1, GRAY_DIS=1, one token, serial 0x2AB_CDEF1 -> RX_FREEZE high 3 cycles before RX_READ, RX_READ high 2 cycles, 60 SHIFT cycles, FIFO_DATA=0x2ABCDEF1, HIT_CNT=1.
REQ-041 GRAY_DIS=0, LE=TE=0x80, ROW=0x05, COL=0x03 -> LE=TE=0xFF in FIFO_DATA; ROW/COL unchanged.
REQ-042 RX_TOKEN held high for 3 words -> STORE goes directly to FREEZE twice; 3 FIFO words, no IDLE cycle between.
REQ-043 FIFO_READ held low, 20 words -> 16 stored, LOST_CNT=4, HIT_CNT=20; pop-and-push at full -> LOST_CNT increments, occupancy stays 15 then 16.
REQ-044 RST during SHIFT -> next cycle IDLE, outputs 0, FIFO_EMPTY=1, counters 0; CONF_EN dropped in LOAD -> word still stored, then IDLE.
